hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/bubble controller for the 5-stage MIPS pipeline.
- Compares register-read requirements of the instruction in D (Tuse) against pending writes in E and M (Tnew).
- Tracks the multiply/divide unit's busy period with an internal countdown.
- Stalls on EPC hazards before eret.
- Drives the F/D register stall enables and the D->E bubble insert.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the busy countdown; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- RESET  in  1  synchronous reset, active high.
- Req  in  1  interrupt/exception entry this cycle.
- D_rs  in  5  rs address of D instruction.
- D_rt  in  5  rt address of D instruction.
- D_rs_tuse  in  2  cycles until rs needed; 3 = not read.
- D_rt_tuse  in  2  cycles until rt needed; 3 = not read.
- D_is_md  in  1  D instruction uses MDU (mult/div/mfhi/mflo/mthi/mtlo).
- D_is_eret  in  1  D instruction is eret.
- E_dst  in  5  destination register of E instruction; 0 = none.
- E_tnew  in  2  cycles until E result is ready.
- M_dst  in  5  destination register of M instruction; 0 = none.
- M_tnew  in  2  cycles until M result is ready.
- E_md_start  in  1  E instruction starts a mult/div this cycle.
- E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- E_mtc0_epc  in  1  E instruction is mtc0 to EPC.
- M_mtc0_epc  in  1  M instruction is mtc0 to EPC.
- F_STALL_EN_N  out  1  1 = hold PC.
- D_STALL_EN_N  out  1  1 = hold F->D register.
- E_CLR  out  1  1 = load bubble (nop) into D->E register.
- md_busy  out  1  MDU countdown nonzero.
- stall_cnt  out  32  total stalled cycles since reset, saturating.

Behaviour:
- Combinational stall terms, all evaluated in the current cycle:
  - stall_rs = (D_rs_tuse != 3) && D_rs != 0 && ((E_dst == D_rs && E_tnew > D_rs_tuse) || (M_dst == D_rs && M_tnew > D_rs_tuse)).
  - stall_rt: same form with rt.
  - stall_md = D_is_md && (E_md_start || md_busy).
  - stall_eret = D_is_eret && (E_mtc0_epc || M_mtc0_epc).
  - stall = (stall_rs | stall_rt | stall_md | stall_eret) && !Req.
- Req suppresses stall; the flush path takes priority.
- F_STALL_EN_N = D_STALL_EN_N = E_CLR = stall. All three are combinational, zero-latency, and always equal.
- Countdown register cnt[CNT_W-1:0], updated on clk rising edge, priority order:
  - RESET: cnt <= 0.
  - E_md_start && !Req: cnt <= E_md_is_div ? DIV_CYCLES : MULT_CYCLES.
  - cnt != 0: cnt <= cnt - 1.
  - otherwise cnt holds.
- md_busy = (cnt != 0), registered-state derived. It is high for exactly N cycles following the start edge.
- Start while busy: not reachable, since stall_md prevents it. If it occurs anyway, reload to the new N (restart wins).
- Req mid-busy: countdown continues. An in-flight MDU operation completes; only a new start is dropped.
- stall_cnt, on clk rising edge:
  - RESET: stall_cnt <= 0.
  - stall && stall_cnt != 32'hFFFFFFFF: stall_cnt <= stall_cnt + 1.
  - At 32'hFFFFFFFF it holds.
- Reset values: cnt = 0, md_busy = 0, stall_cnt = 0.
- Stall outputs after reset depend only on inputs. Zero dst / zero tuse-3 inputs give 0.
- Reset asserted mid-countdown clears cnt on that edge; md_busy = 0 the next cycle.

Decomposition:
- Shared package mips_ctrl_pkg:
  - TUSE_NONE = 2'd3.
  - REG_ZERO = 5'd0.
  - MULT_CYCLES and DIV_CYCLES defaults.
- One natural sub-module: md_busy_timer (countdown plus md_busy).
- Hazard comparison and stall_cnt stay in hazard_ctrl.

Test Plan:
- Load-use: D_rs=5, D_rs_tuse=0, E_dst=5, E_tnew=2 -> all three outputs =1.
  - Then E_dst=0, M_dst=5, M_tnew=1 -> still 1.
  - Then M_tnew=0 -> 0.
  - stall_cnt increments by 2.
- $0 and unread: D_rs=0 with E_dst=0, E_tnew=2 -> no stall.
  - D_rt_tuse=3 with a matching M_dst -> no stall.
- Mult timing: E_md_start=1, E_md_is_div=0 for one cycle; D_is_md=1 held.
  - Stall in the start cycle and for 5 following cycles.
  - md_busy high exactly 5 cycles.
  - Then stall drops.
- Div with Req: E_md_start=1, E_md_is_div=1, Req=1 -> stall 0, cnt stays 0.
  - Repeat without Req -> md_busy high exactly 10 cycles.
  - Asserting Req at cycle 3 does not shorten it.
- eret/EPC: D_is_eret=1, E_mtc0_epc=1 -> stall 1.
  - Next cycle M_mtc0_epc=1 -> stall 1.
  - Then both 0 -> stall 0.
- Reset mid-op: RESET during cycle 4 of a div -> md_busy 0 and stall_cnt 0 after the edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants, hazard request types and the per-source RAW hazard rule
// for the MIPS pipeline control blocks.
package mips_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] tuse;
    } src_req_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } wr_pend_t;

    // A source stalls when a younger-than-needed write to the same register is in flight.
    function automatic logic src_hazard(src_req_t s, wr_pend_t e, wr_pend_t m);
        return (s.tuse != TUSE_NONE) && (s.addr != REG_ZERO) &&
               ((e.dst == s.addr && e.tnew > s.tuse) ||
                (m.dst == s.addr && m.tnew > s.tuse));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide unit busy countdown; md_busy is high for exactly the
// configured number of cycles after an accepted start edge.
module md_busy_timer
    import mips_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic RESET,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;

    // A start while still counting reloads rather than extends.
    always_ff @(posedge clk) begin
        if (RESET)
            cnt <= '0;
        else if (start)
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: RAW, MDU-busy and EPC
// hazards gate F/D and insert a D->E bubble; stalled cycles are counted.
module hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        Req,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic        D_is_eret,
    input  logic [4:0]  E_dst,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_dst,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    input  logic        E_mtc0_epc,
    input  logic        M_mtc0_epc,
    output logic        F_STALL_EN_N,
    output logic        D_STALL_EN_N,
    output logic        E_CLR,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    src_req_t rs_req, rt_req;
    wr_pend_t e_pend, m_pend;
    logic     stall_rs, stall_rt, stall_md, stall_eret, stall;

    assign rs_req = '{addr: D_rs, tuse: D_rs_tuse};
    assign rt_req = '{addr: D_rt, tuse: D_rt_tuse};
    assign e_pend = '{dst: E_dst, tnew: E_tnew};
    assign m_pend = '{dst: M_dst, tnew: M_tnew};

    assign stall_rs   = src_hazard(rs_req, e_pend, m_pend);
    assign stall_rt   = src_hazard(rt_req, e_pend, m_pend);
    assign stall_md   = D_is_md && (E_md_start || md_busy);
    assign stall_eret = D_is_eret && (E_mtc0_epc || M_mtc0_epc);

    // Exception entry flushes the pipe, so it overrides any hold.
    assign stall = (stall_rs || stall_rt || stall_md || stall_eret) && !Req;

    assign F_STALL_EN_N = stall;
    assign D_STALL_EN_N = stall;
    assign E_CLR        = stall;

    // A start that coincides with Req is squashed along with its instruction.
    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .RESET   (RESET),
        .start   (E_md_start && !Req),
        .is_div  (E_md_is_div),
        .md_busy (md_busy)
    );

    always_ff @(posedge clk) begin
        if (RESET)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a rule-level
// model plus hand-computed literal expectations at key points.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        RESET;
    logic        Req;
    logic [4:0]  D_rs, D_rt, E_dst, M_dst;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_is_md, D_is_eret, E_md_start, E_md_is_div, E_mtc0_epc, M_mtc0_epc;
    logic        F_STALL_EN_N, D_STALL_EN_N, E_CLR, md_busy;
    logic [31:0] stall_cnt;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .RESET(RESET), .Req(Req),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_is_md(D_is_md), .D_is_eret(D_is_eret),
        .E_dst(E_dst), .E_tnew(E_tnew), .M_dst(M_dst), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .E_mtc0_epc(E_mtc0_epc), .M_mtc0_epc(M_mtc0_epc),
        .F_STALL_EN_N(F_STALL_EN_N), .D_STALL_EN_N(D_STALL_EN_N), .E_CLR(E_CLR),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    // Model: the MDU is busy for md_len cycles counted from the edge that accepted
    // the start (absolute edge numbers), stall_cnt counts stalled cycles since reset.
    longint      edge_n  = 0;
    longint      md_from = 0;
    longint      md_len  = 0;
    logic [31:0] exp_cnt = 32'd0;

    function automatic bit m_busy();
        return (edge_n - md_from) < md_len;
    endfunction

    function automatic bit exp_stall();
        logic [4:0] src [2];
        logic [1:0] tu  [2];
        logic [4:0] dst [2];
        logic [1:0] tn  [2];
        bit hz = 1'b0;
        src[0] = D_rs;  src[1] = D_rt;
        tu[0]  = D_rs_tuse; tu[1] = D_rt_tuse;
        dst[0] = E_dst; dst[1] = M_dst;
        tn[0]  = E_tnew; tn[1] = M_tnew;
        for (int s = 0; s < 2; s++)
            if (tu[s] != 2'd3 && src[s] != 5'd0)
                for (int p = 0; p < 2; p++)
                    if (dst[p] == src[s] && tn[p] > tu[s]) hz = 1'b1;
        if (D_is_md && (E_md_start || m_busy())) hz = 1'b1;
        if (D_is_eret && (E_mtc0_epc || M_mtc0_epc)) hz = 1'b1;
        return hz && !Req;
    endfunction

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (RESET) begin
            md_len  <= 0;
            exp_cnt <= 32'd0;
        end else begin
            if (exp_stall() && exp_cnt != 32'hFFFF_FFFF) exp_cnt <= exp_cnt + 32'd1;
            if (E_md_start && !Req) begin
                md_from <= edge_n + 1;
                md_len  <= E_md_is_div ? 10 : 5;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("F_STALL_EN_N", {31'd0, F_STALL_EN_N}, {31'd0, exp_stall()});
            chk("D_STALL_EN_N", {31'd0, D_STALL_EN_N}, {31'd0, exp_stall()});
            chk("E_CLR",        {31'd0, E_CLR},        {31'd0, exp_stall()});
            chk("md_busy",      {31'd0, md_busy},      {31'd0, m_busy()});
            chk("stall_cnt",    stall_cnt,             exp_cnt);
        end
    end

    task automatic settle(); @(negedge clk); endtask
    task automatic adv();    @(posedge clk); #1; endtask

    task automatic clr_in();
        Req = 0; D_rs = 0; D_rt = 0; D_rs_tuse = 3; D_rt_tuse = 3;
        D_is_md = 0; D_is_eret = 0; E_dst = 0; E_tnew = 0; M_dst = 0; M_tnew = 0;
        E_md_start = 0; E_md_is_div = 0; E_mtc0_epc = 0; M_mtc0_epc = 0;
    endtask

    task automatic lit_stall(input string nm, input bit exp);
        chk({nm, ".F"}, {31'd0, F_STALL_EN_N}, {31'd0, exp});
        chk({nm, ".D"}, {31'd0, D_STALL_EN_N}, {31'd0, exp});
        chk({nm, ".E"}, {31'd0, E_CLR},        {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        RESET = 1;
        adv();
        chk_en = 1'b1;
        adv();
        settle();
        chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        lit_stall("rst", 1'b0);
        adv();
        RESET = 0;

        // Load-use through E then M
        D_rs = 5; D_rs_tuse = 0; E_dst = 5; E_tnew = 2;
        settle(); lit_stall("lu_e", 1'b1);
        adv(); E_dst = 0; M_dst = 5; M_tnew = 1;
        settle(); lit_stall("lu_m", 1'b1);
        adv(); M_tnew = 0;
        settle(); lit_stall("lu_ready", 1'b0);
        chk("lu.stall_cnt", stall_cnt, 32'd2);
        chk("lu.model_cnt", exp_cnt, 32'd2);

        // $0 and unread operands, tnew == tuse boundary
        adv(); clr_in(); D_rs = 0; D_rs_tuse = 0; E_dst = 0; E_tnew = 2;
        settle(); lit_stall("zero_reg", 1'b0);
        adv(); clr_in(); D_rt = 7; D_rt_tuse = 3; M_dst = 7; M_tnew = 2;
        settle(); lit_stall("rt_unread", 1'b0);
        adv(); D_rt_tuse = 1;
        settle(); lit_stall("rt_read", 1'b1);
        adv(); D_rt_tuse = 2;
        settle(); lit_stall("tnew_eq_tuse", 1'b0);

        // Mult: stall in start cycle plus 5 busy cycles
        adv(); clr_in(); D_is_md = 1; E_md_start = 1;
        settle(); lit_stall("mult_start", 1'b1);
        chk("mult_start.busy", {31'd0, md_busy}, 32'd0);
        adv(); E_md_start = 0;
        for (int k = 1; k <= 5; k++) begin
            settle();
            chk($sformatf("mult_busy%0d", k), {31'd0, md_busy}, 32'd1);
            lit_stall($sformatf("mult_stall%0d", k), 1'b1);
            adv();
        end
        settle();
        chk("mult_done.busy", {31'd0, md_busy}, 32'd0);
        lit_stall("mult_done", 1'b0);

        // Div start squashed by Req
        adv(); clr_in(); D_is_md = 1; E_md_start = 1; E_md_is_div = 1; Req = 1;
        settle(); lit_stall("div_req", 1'b0);
        adv(); clr_in();
        settle(); chk("div_req.busy", {31'd0, md_busy}, 32'd0);

        // Div without Req, Req pulse at busy cycle 3 must not shorten it
        adv(); E_md_start = 1; E_md_is_div = 1;
        adv(); E_md_start = 0; E_md_is_div = 0;
        for (int k = 1; k <= 10; k++) begin
            Req = (k == 3);
            settle();
            chk($sformatf("div_busy%0d", k), {31'd0, md_busy}, 32'd1);
            adv();
        end
        Req = 0;
        settle(); chk("div_done.busy", {31'd0, md_busy}, 32'd0);

        // Restart while busy: reload wins
        adv(); E_md_start = 1;
        adv(); E_md_start = 0;
        adv(); E_md_start = 1; E_md_is_div = 1;
        adv(); clr_in();
        repeat (11) adv();

        // eret behind mtc0 EPC
        clr_in(); D_is_eret = 1; E_mtc0_epc = 1;
        settle(); lit_stall("eret_e", 1'b1);
        adv(); E_mtc0_epc = 0; M_mtc0_epc = 1;
        settle(); lit_stall("eret_m", 1'b1);
        adv(); M_mtc0_epc = 0;
        settle(); lit_stall("eret_clear", 1'b0);

        // Reset during busy cycle 4 of a div, with a stall present on that edge
        adv(); clr_in(); E_md_start = 1; E_md_is_div = 1;
        adv(); clr_in();
        repeat (3) adv();
        RESET = 1; D_is_md = 1;
        settle();
        chk("rst_mid.busy_before", {31'd0, md_busy}, 32'd1);
        lit_stall("rst_mid.stall", 1'b1);
        adv(); RESET = 0; D_is_md = 0;
        settle();
        chk("rst_mid.busy", {31'd0, md_busy}, 32'd0);
        chk("rst_mid.stall_cnt", stall_cnt, 32'd0);
        adv();
        settle();
        chk("rst_mid.busy_after", {31'd0, md_busy}, 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
